// File: rtl/ftdi_echo_fifo_if.sv
// Bundle of the loopback FIFO's handshake, data and status signals.
// The slave side is the echo FIFO; the master side is whatever plays the
// ftdiController user port (the controller glue, or a bench).
interface ftdi_echo_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_loop_en;
  logic          out_rx_en;
  logic          in_rx_hsk_req;
  logic [7:0]    in_rx_data;
  logic          out_rx_hsk_ack;
  logic          out_tx_hsk_req;
  logic [7:0]    out_tx_data;
  logic          in_tx_hsk_ack;
  logic [LW-1:0] out_level;
  logic          out_empty;
  logic          out_full;
  logic [15:0]   out_byte_count;

  modport slave (
    input  in_loop_en,
    input  in_rx_hsk_req,
    input  in_rx_data,
    input  in_tx_hsk_ack,
    output out_rx_en,
    output out_rx_hsk_ack,
    output out_tx_hsk_req,
    output out_tx_data,
    output out_level,
    output out_empty,
    output out_full,
    output out_byte_count
  );

  modport master (
    output in_loop_en,
    output in_rx_hsk_req,
    output in_rx_data,
    output in_tx_hsk_ack,
    input  out_rx_en,
    input  out_rx_hsk_ack,
    input  out_tx_hsk_req,
    input  out_tx_data,
    input  out_level,
    input  out_empty,
    input  out_full,
    input  out_byte_count
  );
endinterface

// File: rtl/ftdi_echo_fifo.sv
// USB loopback FIFO sitting on the user side of ftdiController.
// Received bytes arrive over a 4-phase req/ack handshake, are buffered in a
// synchronous FIFO and are sent back in order over the TX 4-phase handshake.
// Backpressure is signalled early through out_rx_en; a request that is already
// in flight when the FIFO fills is simply stalled (never dropped).
module ftdi_echo_fifo #(
  parameter int DEPTH        = 16,
  parameter int RX_EN_MARGIN = 2
) (
  input logic             in_clk,
  input logic             in_reset_n,
  ftdi_echo_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] MARGIN_L = LW'(RX_EN_MARGIN);

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_WAIT
  } tx_state_t;

  // Reset synchroniser: assertion is immediate, release is aligned to clk.
  logic [1:0] rst_pipe_q;
  logic       rst_n_int;

  // FIFO storage (no reset so it can map onto block RAM).
  logic [7:0] mem_q [DEPTH];

  // Sequential state and its next-state values.
  rx_state_t     rx_state_q,   rx_state_d;
  logic          rx_ack_q,     rx_ack_d;
  tx_state_t     tx_state_q,   tx_state_d;
  logic          tx_req_q,     tx_req_d;
  logic [7:0]    tx_data_q;
  logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,     rd_ptr_d;
  logic [LW-1:0] level_q,      level_d;
  logic [15:0]   byte_count_q, byte_count_d;
  logic          rx_en_q,      rx_en_d;

  // Per-cycle FIFO events.
  logic push;
  logic pop;
  logic full;
  logic empty;

  assign full      = (level_q == DEPTH_L);
  assign empty     = (level_q == '0);
  assign rst_n_int = rst_pipe_q[1];

  // Two-flop reset release so the internal reset deasserts synchronously.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      rst_pipe_q <= 2'b00;
    end else begin
      rst_pipe_q <= {rst_pipe_q[0], 1'b1};
    end
  end

  // RX handshake: accept a byte only when there is room, then wait for req low.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_ack_d   = rx_ack_q;
    push       = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (bus.in_rx_hsk_req && !full) begin
          push       = 1'b1;
          rx_ack_d   = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!bus.in_rx_hsk_req) begin
          rx_ack_d   = 1'b0;
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_ack_d   = 1'b0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // TX handshake: pop one byte, raise req, count it when the controller acks.
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_req_d     = tx_req_q;
    byte_count_d = byte_count_q;
    pop          = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.in_loop_en && !empty) begin
          pop        = 1'b1;
          tx_req_d   = 1'b1;
          tx_state_d = TX_REQ;
        end
      end
      TX_REQ: begin
        if (bus.in_tx_hsk_ack) begin
          tx_req_d     = 1'b0;
          byte_count_d = byte_count_q + 16'd1;
          tx_state_d   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (!bus.in_tx_hsk_ack) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        tx_req_d   = 1'b0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // Pointer and occupancy bookkeeping; rx_en is decoded from the next level
  // so the registered output always matches the registered level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    rx_en_d = ((DEPTH_L - level_d) > MARGIN_L);
  end

  // FIFO write port.
  always_ff @(posedge in_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_rx_data;
    end
  end

  // State registers, registered FIFO read and status counters.
  always_ff @(posedge in_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rx_state_q   <= RX_IDLE;
      rx_ack_q     <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_req_q     <= 1'b0;
      tx_data_q    <= 8'h00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      byte_count_q <= 16'h0000;
      rx_en_q      <= 1'b1;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_ack_q     <= rx_ack_d;
      tx_state_q   <= tx_state_d;
      tx_req_q     <= tx_req_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      byte_count_q <= byte_count_d;
      rx_en_q      <= rx_en_d;
      // Only a popped entry is read; it was written at least one edge earlier,
      // and out_tx_data keeps its value after req falls.
      if (pop) begin
        tx_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign bus.out_rx_en      = rx_en_q;
  assign bus.out_rx_hsk_ack = rx_ack_q;
  assign bus.out_tx_hsk_req = tx_req_q;
  assign bus.out_tx_data    = tx_data_q;
  assign bus.out_level      = level_q;
  assign bus.out_empty      = empty;
  assign bus.out_full       = full;
  assign bus.out_byte_count = byte_count_q;

endmodule

// File: tb/tb_ftdi_echo_fifo.sv
// Directed and random loopback bench for ftdi_echo_fifo with a byte scoreboard.
module tb_ftdi_echo_fifo;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;
  int peak     = 0;

  logic [7:0] sb[$];

  ftdi_echo_fifo_if #(.DEPTH(DEPTH)) bus ();

  ftdi_echo_fifo #(
    .DEPTH       (DEPTH),
    .RX_EN_MARGIN(MARGIN)
  ) dut (
    .in_clk    (clk),
    .in_reset_n(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (int'(bus.out_level) > peak) peak = int'(bus.out_level);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Controller RX side: present a byte and complete the 4-phase handshake.
  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    bus.in_rx_data    = d;
    bus.in_rx_hsk_req = 1'b1;
    sb.push_back(d);
    do begin tick(); n++; end while (bus.out_rx_hsk_ack !== 1'b1 && n < 40);
    check("rx_ack_rise", bus.out_rx_hsk_ack, 1);
    bus.in_rx_hsk_req = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.out_rx_hsk_ack !== 1'b0 && n < 40);
    check("rx_ack_fall", bus.out_rx_hsk_ack, 0);
  endtask

  // Controller TX side: wait for req, compare against scoreboard, ack after delay.
  task automatic recv_byte(input int delay);
    int n = 0;
    logic [7:0] e;
    while (bus.out_tx_hsk_req !== 1'b1 && n < 40) begin tick(); n++; end
    check("tx_req_rise", bus.out_tx_hsk_req, 1);
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    check("tx_data", bus.out_tx_data, e);
    repeat (delay) tick();
    bus.in_tx_hsk_ack = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.out_tx_hsk_req !== 1'b0 && n < 40);
    check("tx_req_fall", bus.out_tx_hsk_req, 0);
    bus.in_tx_hsk_ack = 1'b0;
    tick();
  endtask

  initial begin
    logic ack_seen;

    // Reset with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_loop_en    = 1'($urandom_range(0, 1));
      bus.in_rx_hsk_req = 1'($urandom_range(0, 1));
      bus.in_rx_data    = 8'($urandom);
      bus.in_tx_hsk_ack = 1'($urandom_range(0, 1));
      tick();
    end
    check("rst_rx_ack", bus.out_rx_hsk_ack, 0);
    check("rst_tx_req", bus.out_tx_hsk_req, 0);
    check("rst_tx_data", bus.out_tx_data, 0);
    check("rst_level", bus.out_level, 0);
    check("rst_empty", bus.out_empty, 1);
    check("rst_full", bus.out_full, 0);
    check("rst_rx_en", bus.out_rx_en, 1);
    check("rst_byte_count", bus.out_byte_count, 0);
    bus.in_loop_en    = 1'b0;
    bus.in_rx_hsk_req = 1'b0;
    bus.in_rx_data    = 8'h00;
    bus.in_tx_hsk_ack = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();

    // Single echo with exact latency.
    bus.in_loop_en    = 1'b1;
    bus.in_rx_data    = 8'hA5;
    bus.in_rx_hsk_req = 1'b1;
    sb.push_back(8'hA5);
    tick();
    check("echo_ack", bus.out_rx_hsk_ack, 1);
    check("echo_level1", bus.out_level, 1);
    check("echo_req_not_yet", bus.out_tx_hsk_req, 0);
    bus.in_rx_hsk_req = 1'b0;
    tick();
    check("echo_tx_req", bus.out_tx_hsk_req, 1);
    check("echo_level0", bus.out_level, 0);
    check("echo_ack_low", bus.out_rx_hsk_ack, 0);
    recv_byte(0);
    check("echo_byte_count", bus.out_byte_count, 1);
    check("echo_empty", bus.out_empty, 1);

    // Fill with loop disabled, watch backpressure.
    bus.in_loop_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(i));
      check("fill_level", bus.out_level, i + 1);
      check("fill_rx_en", bus.out_rx_en, ((DEPTH - (i + 1)) > MARGIN) ? 1 : 0);
    end
    check("fill_full", bus.out_full, 1);
    bus.in_rx_data    = 8'h10;
    bus.in_rx_hsk_req = 1'b1;
    sb.push_back(8'h10);
    ack_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_rx_hsk_ack === 1'b1) ack_seen = 1'b1;
    end
    check("full_stall_no_ack", ack_seen, 0);
    check("full_stall_level", bus.out_level, DEPTH);
    bus.in_loop_en = 1'b1;
    tick();
    check("drain_first_pop_req", bus.out_tx_hsk_req, 1);
    check("drain_ack_held", bus.out_rx_hsk_ack, 0);
    check("drain_level15", bus.out_level, DEPTH - 1);
    tick();
    check("drain_ack_after_pop", bus.out_rx_hsk_ack, 1);
    check("drain_level16", bus.out_level, DEPTH);
    bus.in_rx_hsk_req = 1'b0;
    tick();
    for (int i = 0; i < DEPTH + 1; i++) recv_byte(0);
    check("drain_level_end", bus.out_level, 0);
    check("drain_rx_en_end", bus.out_rx_en, 1);
    check("drain_byte_count", bus.out_byte_count, 18);

    // Simultaneous push and pop at level 3.
    bus.in_loop_en = 1'b0;
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    check("sim_level_before", bus.out_level, 3);
    bus.in_loop_en    = 1'b1;
    bus.in_rx_data    = 8'h44;
    bus.in_rx_hsk_req = 1'b1;
    sb.push_back(8'h44);
    tick();
    check("sim_level_same", bus.out_level, 3);
    check("sim_rx_ack", bus.out_rx_hsk_ack, 1);
    check("sim_tx_req", bus.out_tx_hsk_req, 1);
    bus.in_rx_hsk_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) recv_byte(1);
    check("sim_byte_count", bus.out_byte_count, 22);

    // Asynchronous reset during TX_REQ with 5 bytes still queued.
    bus.in_loop_en = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h50 + i));
    bus.in_loop_en = 1'b1;
    tick();
    check("mid_tx_req", bus.out_tx_hsk_req, 1);
    check("mid_level5", bus.out_level, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_tx_req", bus.out_tx_hsk_req, 0);
    check("async_level", bus.out_level, 0);
    check("async_empty", bus.out_empty, 1);
    check("async_rx_en", bus.out_rx_en, 1);
    check("async_byte_count", bus.out_byte_count, 0);
    check("async_tx_data", bus.out_tx_data, 0);
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'h3C);
    recv_byte(2);
    check("post_rst_byte_count", bus.out_byte_count, 1);
    check("post_rst_level", bus.out_level, 0);

    // Random stress from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    peak = 0;
    tick();
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 7)) tick();
          send_byte(8'($urandom));
        end
      end
      begin
        for (int j = 0; j < 300; j++) recv_byte(int'($urandom_range(0, 7)));
      end
    join
    check("stress_byte_count", bus.out_byte_count, 300);
    check("stress_sb_empty", sb.size(), 0);
    check("stress_level", bus.out_level, 0);
    check("stress_no_overflow", (peak > DEPTH) ? 1 : 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ftdi_echo_fifo.md
Name: ftdi_echo_fifo

Overview:
- User-side neighbour of ftdiController, clocked on the same in_clk.
- Consumes received bytes over the controller's RX req/ack handshake and buffers them in a synchronous FIFO.
- Returns the bytes in order over the controller's TX req/ack handshake, giving a USB loopback path.
- Applies backpressure through the controller's RX enable.

Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥4.
- RX_EN_MARGIN, 2: out_rx_en deasserts when free entries ≤ RX_EN_MARGIN.

Ports:
- in_clk  input  1  system clock; all logic on the rising edge.
- in_reset_n  input  1  reset, asynchronous, active-low.
- in_loop_en  input  1  1 = drain FIFO to TX; 0 = hold TX idle (RX still fills).
- out_rx_en  output  1  to controller in_rx_en.
- in_rx_hsk_req  input  1  from controller out_rx_hsk_req.
- in_rx_data  input  8  from controller out_rx_data; stable while req high.
- out_rx_hsk_ack  output  1  to controller in_rx_hsk_ack.
- out_tx_hsk_req  output  1  to controller in_tx_hsk_req.
- out_tx_data  output  8  to controller in_tx_data; stable while req high.
- in_tx_hsk_ack  input  1  from controller out_tx_hsk_ack.
- out_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- out_empty  output  1  level == 0.
- out_full  output  1  level == DEPTH.
- out_byte_count  output  16  bytes whose TX handshake completed; wraps 0xFFFF→0.

Behaviour:
- Reset (async assert, sync deassert inside):
  - pointers, level and out_byte_count = 0.
  - out_rx_hsk_ack, out_tx_hsk_req = 0; out_tx_data = 0.
  - out_empty = 1, out_full = 0, out_rx_en = 1.
  - Both FSMs enter IDLE.
  - Reset mid-handshake drops the byte in flight; no recovery state is kept.
- Handshake inputs are same-domain; no synchronisers.
- RX FSM (4-phase handshake):
  - RX_IDLE: at an edge where in_rx_hsk_req=1 and level<DEPTH, write in_rx_data at wr_ptr, wr_ptr++, out_rx_hsk_ack←1, go RX_ACK. If full, stay and keep ack low (stall; never drop, never overwrite).
  - RX_ACK: when in_rx_hsk_req=0, ack←0, go RX_IDLE.
  - Minimum 2 cycles per byte.
- TX FSM (4-phase handshake):
  - TX_IDLE: when in_loop_en=1 and level>0, out_tx_data←mem[rd_ptr], rd_ptr++, out_tx_hsk_req←1, go TX_REQ.
  - TX_REQ: when in_tx_hsk_ack=1, req←0, out_byte_count++, go TX_WAIT.
  - TX_WAIT: when in_tx_hsk_ack=0, go TX_IDLE.
  - Dropping in_loop_en mid-transfer does not abort the current byte.
- Latency: a byte written at edge N is seen as non-empty from edge N; out_tx_hsk_req rises at edge N+1 (1 cycle), given TX_IDLE and loop enabled.
- Level:
  - +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- out_rx_en = (DEPTH − level) > RX_EN_MARGIN, decoded from registered level (glitch-free).
  - The controller may still present a request already in flight; the full-stall rule covers it.
- Data order is strictly FIFO.
- out_tx_data holds its last value after req falls.

Test Plan:
- Reset: hold in_reset_n=0 with random inputs → ack=0, tx_req=0, level=0, empty=1, full=0, rx_en=1, byte_count=0; async assertion mid-transfer clears outputs without a clock edge.
- Single echo, loop_en=1: RX req with 0xA5 → ack high next edge, level=1; tx_req high one edge later with tx_data=0xA5; bench acks → req low, byte_count=1, level=0.
- Fill and backpressure, loop_en=0: send 0x00..0x0F → rx_en falls when level reaches 14; full=1 at 16; 17th req (0x10) not acked for 20 cycles. Set loop_en=1 → TX emits 0x00 first, 0x10 acked after that pop, then output order is 0x01..0x0F,0x10.
- Simultaneous push/pop: level=3, RX push and TX pop on the same edge → level stays 3, data order intact.
- Reset mid-operation: assert in_reset_n=0 during TX_REQ with level=5 → req=0, level=0 immediately; after release a new byte 0x3C echoes correctly.
- Stress: 300 random bytes, random ack delays 0–7 cycles on both sides → output stream equals input stream, byte_count=300, never overflows.
